// File: rtl/jtopl_eg_mslot.sv
// Time-multiplexed ADSR envelope generator: one operator slot is evaluated per cen pulse,
// with per-slot attenuation/state memories and a shared global envelope counter.
module jtopl_eg_mslot #(
    parameter int SLOTS = 18,
    parameter int EGW   = 10,
    parameter int CNTW  = 15,
    localparam int SW   = $clog2(SLOTS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           eg_stop,
    input  logic           all_off,
    input  logic           keyon,
    input  logic           en_sus,
    input  logic [3:0]     arate,
    input  logic [3:0]     drate,
    input  logic [3:0]     rrate,
    input  logic [3:0]     sl,
    input  logic           ksr,
    input  logic [3:0]     keycode,
    input  logic [5:0]     tl,
    input  logic [3:0]     am,
    input  logic           amsen,
    output logic [SW-1:0]  slot,
    output logic           zero,
    output logic [SW-1:0]  out_slot,
    output logic [EGW-1:0] eg_out,
    output logic           pg_rst,
    output logic [1:0]     state_out
);

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } eg_state_t;

    logic [EGW-1:0]  eg_mem [SLOTS];
    eg_state_t       st_mem [SLOTS];
    logic [SLOTS-1:0] kon_last;
    logic [SW-1:0]   slot_r;
    logic [CNTW-1:0] eg_cnt;

    logic [EGW-1:0]  cur_eg, nxt_eg, out_eg, sl_level, eg_sat;
    eg_state_t       cur_st, nxt_st, out_st;
    logic            cur_kon, nxt_pg, out_pg;
    logic [3:0]      hi_a, hi_d, hi_r;
    logic [EGW+1:0]  out_sum;

    // Upper nibble of the key-scaled effective rate, clamped to 63.
    function automatic logic [3:0] rate_hi(input logic [3:0] rate, input logic ksr_i,
                                           input logic [3:0] kc);
        logic [3:0] ks;
        logic [6:0] eff;
        ks  = ksr_i ? kc : {2'b00, kc[3:2]};
        eff = {1'b0, rate, 2'b00} + {3'b000, ks};
        if (rate == 4'd0) return 4'd0;
        if (eff > 7'd63) return 4'd15;
        return 4'(eff >> 2);
    endfunction

    function automatic logic step_ok(input logic [3:0] hi, input logic [CNTW-1:0] cnt);
        logic [CNTW-1:0] mask;
        mask = (CNTW'(1) << (4'd13 - hi)) - CNTW'(1);
        if (hi == 4'd0) return 1'b0;
        if (hi >= 4'd13) return 1'b1;
        return (cnt & mask) == '0;
    endfunction

    function automatic logic [EGW-1:0] sat_add(input logic [EGW-1:0] eg, input logic [3:0] hi);
        logic [EGW:0]   s;
        logic [EGW-1:0] inc;
        inc = (hi >= 4'd13) ? (EGW'(1) << (hi - 4'd12)) : EGW'(1);
        s   = {1'b0, eg} + {1'b0, inc};
        return s[EGW] ? '1 : s[EGW-1:0];
    endfunction

    function automatic logic [EGW-1:0] att_step(input logic [EGW-1:0] eg, input logic [3:0] hi);
        logic [1:0]     sh;
        logic [EGW-1:0] dec;
        sh  = (hi >= 4'd13) ? 2'(4'd15 - hi) : 2'd3;
        dec = (eg >> sh) + EGW'(1);
        return (eg >= dec) ? (eg - dec) : '0;
    endfunction

    assign slot     = slot_r;
    assign zero     = (slot_r == SW'(SLOTS - 1));
    assign sl_level = (sl == 4'hF) ? '1 : {sl, {(EGW-4){1'b0}}};

    // Next per-slot state: all_off beats key edges, key edges beat rate-driven steps.
    always_comb begin
        cur_eg  = eg_mem[slot_r];
        cur_st  = st_mem[slot_r];
        cur_kon = kon_last[slot_r];
        hi_a    = rate_hi(arate, ksr, keycode);
        hi_d    = rate_hi(drate, ksr, keycode);
        hi_r    = rate_hi(rrate, ksr, keycode);
        nxt_eg  = cur_eg;
        nxt_st  = cur_st;
        nxt_pg  = 1'b0;
        if (all_off) begin
            nxt_st = RELEASE;
        end else if (keyon && !cur_kon) begin
            nxt_pg = 1'b1;
            if (hi_a == 4'd15) begin
                nxt_eg = '0;
                nxt_st = DECAY;
            end else begin
                nxt_st = ATTACK;
            end
        end else if (!keyon && cur_kon) begin
            nxt_st = RELEASE;
        end else begin
            case (cur_st)
                ATTACK: begin
                    if (hi_a == 4'd15) nxt_eg = '0;
                    else if (step_ok(hi_a, eg_cnt)) nxt_eg = att_step(cur_eg, hi_a);
                    if (nxt_eg == '0) nxt_st = DECAY;
                end
                DECAY: begin
                    if (step_ok(hi_d, eg_cnt)) nxt_eg = sat_add(cur_eg, hi_d);
                    if (nxt_eg >= sl_level) nxt_st = SUSTAIN;
                end
                SUSTAIN: begin
                    if (!en_sus && step_ok(hi_r, eg_cnt)) nxt_eg = sat_add(cur_eg, hi_r);
                end
                default: begin
                    if (step_ok(hi_r, eg_cnt)) nxt_eg = sat_add(cur_eg, hi_r);
                end
            endcase
        end
    end

    // While frozen, outputs still report the stored slot contents.
    always_comb begin
        out_eg  = eg_stop ? cur_eg : nxt_eg;
        out_st  = eg_stop ? cur_st : nxt_st;
        out_pg  = eg_stop ? 1'b0   : nxt_pg;
        out_sum = {2'b00, out_eg} + ((EGW+2)'(tl) << (EGW - 7))
                + (amsen ? ((EGW+2)'(am) << (EGW - 9)) : '0);
        eg_sat  = (|out_sum[EGW+1:EGW]) ? '1 : out_sum[EGW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                eg_mem[i] <= '1;
                st_mem[i] <= RELEASE;
            end
            kon_last  <= '0;
            slot_r    <= '0;
            eg_cnt    <= '0;
            eg_out    <= '1;
            pg_rst    <= 1'b0;
            out_slot  <= '0;
            state_out <= 2'd3;
        end else if (cen) begin
            if (!eg_stop) begin
                eg_mem[slot_r]   <= nxt_eg;
                st_mem[slot_r]   <= nxt_st;
                kon_last[slot_r] <= keyon;
                if (zero) eg_cnt <= eg_cnt + CNTW'(1);
            end
            eg_out    <= eg_sat;
            pg_rst    <= out_pg;
            out_slot  <= slot_r;
            state_out <= out_st;
            slot_r    <= zero ? '0 : slot_r + SW'(1);
        end
    end

endmodule

// File: tb/tb_jtopl_eg_mslot.sv
// Directed bench for jtopl_eg_mslot: drives slot 3 through attack, decay, sustain,
// release, panic release, freeze and output saturation with hand-computed values.
module tb_jtopl_eg_mslot;

    logic       clk, rst_n, cen, eg_stop, all_off, keyon, en_sus, ksr, amsen;
    logic [3:0] arate, drate, rrate, sl, keycode, am;
    logic [5:0] tl;
    logic [4:0] slot, out_slot;
    logic       zero, pg_rst;
    logic [9:0] eg_out;
    logic [1:0] state_out;

    int checks = 0;
    int errors = 0;

    logic [9:0] cap_eg, prev_eg;
    logic [1:0] cap_st;
    logic       cap_pg;
    logic [4:0] cap_slot;

    jtopl_eg_mslot #(.SLOTS(18), .EGW(10), .CNTW(15)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .eg_stop(eg_stop), .all_off(all_off),
        .keyon(keyon), .en_sus(en_sus), .arate(arate), .drate(drate), .rrate(rrate),
        .sl(sl), .ksr(ksr), .keycode(keycode), .tl(tl), .am(am), .amsen(amsen),
        .slot(slot), .zero(zero), .out_slot(out_slot), .eg_out(eg_out),
        .pg_rst(pg_rst), .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full scan round; only slot 3 sees the given key/all_off values.
    task automatic applyStimulus(input logic kon3, input logic off3, input bit chk_scan);
        for (int s = 0; s < 18; s++) begin
            keyon   = (s == 3) ? kon3 : 1'b0;
            all_off = (s == 3) ? off3 : 1'b0;
            if (chk_scan) begin
                checkOutput("slot", slot, s);
                checkOutput("zero", zero, (s == 17) ? 1 : 0);
            end
            @(posedge clk);
            #1;
            if (s == 3) begin
                cap_eg   = eg_out;
                cap_st   = state_out;
                cap_pg   = pg_rst;
                cap_slot = out_slot;
            end
        end
        keyon   = 1'b0;
        all_off = 1'b0;
    endtask

    initial begin
        clk = 0; rst_n = 0; cen = 0; eg_stop = 0; all_off = 0; keyon = 0;
        en_sus = 1; arate = 15; drate = 15; rrate = 15; sl = 2; ksr = 0;
        keycode = 0; tl = 0; am = 0; amsen = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_eg_out", eg_out, 10'h3FF);
        checkOutput("rst_state", state_out, 3);
        checkOutput("rst_pg", pg_rst, 0);
        checkOutput("rst_slot", slot, 0);
        checkOutput("rst_out_slot", out_slot, 0);
        rst_n = 1;
        cen   = 1;

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idle_eg", cap_eg, 10'h3FF);
        checkOutput("idle_state", cap_st, 3);
        checkOutput("idle_out_slot", cap_slot, 3);

        // Key-on with the fastest attack lands straight in DECAY at zero
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("kon_eg", cap_eg, 0);
        checkOutput("kon_pg", cap_pg, 1);
        checkOutput("kon_state", cap_st, 1);

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("decay_eg", cap_eg, 8 * i);
            checkOutput("decay_state", cap_st, (i == 16) ? 2 : 1);
            checkOutput("decay_pg", cap_pg, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sus_hold_eg", cap_eg, 128);
        checkOutput("sus_hold_state", cap_st, 2);

        en_sus = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sus_rrate_eg", cap_eg, 136);
        checkOutput("sus_rrate_state", cap_st, 2);
        en_sus = 1;

        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("koff_state", cap_st, 3);
        prev_eg = cap_eg;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rel_step", cap_eg, prev_eg + 10'd8);
        repeat (115) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rel_sat_eg", cap_eg, 10'h3FF);
        checkOutput("rel_sat_state", cap_st, 3);

        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("alloff_state", cap_st, 3);
        checkOutput("alloff_pg", cap_pg, 0);
        checkOutput("alloff_eg", cap_eg, 10'h3FF);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Key-on arriving while frozen must be deferred
        arate   = 4;
        eg_stop = 1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stop_eg", cap_eg, 10'h3FF);
        checkOutput("stop_state", cap_st, 3);
        checkOutput("stop_pg", cap_pg, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stop_eg2", cap_eg, 10'h3FF);
        eg_stop = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("unstop_state", cap_st, 0);
        checkOutput("unstop_pg", cap_pg, 1);

        arate = 13;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("att13_eg1", cap_eg, 767);
        checkOutput("att13_state", cap_st, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("att13_eg2", cap_eg, 575);

        arate = 15;
        sl    = 15;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("att15_eg", cap_eg, 0);
        checkOutput("att15_state", cap_st, 1);
        repeat (120) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ramp_eg", cap_eg, 10'h3C0);
        checkOutput("ramp_state", cap_st, 1);

        eg_stop = 1;
        tl      = 63;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tl_sat", cap_eg, 10'h3FF);
        tl    = 0;
        am    = 4;
        amsen = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("am_add", cap_eg, 10'h3C8);
        eg_stop = 0;
        am      = 0;
        amsen   = 0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tl    = 1;
        am    = 4;
        amsen = 1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("tl_am_sum", cap_eg, 16);
        checkOutput("tl_am_pg", cap_pg, 1);

        // Asynchronous reset in the middle of a scan
        repeat (7) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        checkOutput("midrst_slot", slot, 0);
        checkOutput("midrst_eg", eg_out, 10'h3FF);
        checkOutput("midrst_state", state_out, 3);
        @(posedge clk);
        #1;
        rst_n = 1;
        tl    = 0;
        amsen = 0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("post_rst_eg", cap_eg, 10'h3FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
